mem_block_initiator: RTL

- Memory-side initiator of the cache refill/writeback path; it is the requester that drives the block memory's address/data/write-enable interface and collects its block responses.
- Accepts one miss request at a time from the cache controller. If the request is dirty, it first writes back the victim block, then refills the requested block. It returns the refill block with a one-cycle response pulse.
- Owns the memory protocol rule: the memory starts an operation only when its address changes and then stays stable, so every operation is preceded by a one-cycle address "kick".

---
 rtl/mem_block_initiator.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_block_initiator.sv
// Cache-side requester for the block memory: optional victim writeback, then refill.
// Every memory operation starts with a one-cycle address kick so the memory sees a change.
module mem_block_initiator #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 10,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  localparam int BLOCK_SIZE        = 1 << BLOCK_OFFSET_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_dirty,
  input  logic [ADDR_WIDTH-1:0]            req_wb_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] req_wb_data,
  output logic                             resp_valid,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_we,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_block_din,
  input  logic                             mem_valid,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_block_dout,
  output logic [15:0]                      last_latency
);

  localparam logic [ADDR_WIDTH-1:0] KICK_BIT    = ADDR_WIDTH'(1) << BLOCK_OFFSET_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = KICK_BIT - ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_KICK = 3'd1,
    WB_WAIT = 3'd2,
    RD_KICK = 3'd3,
    RD_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]            wb_addr_q, wb_addr_d;
  logic                             seen_low_q, seen_low_d;
  logic [15:0]                      lat_q, lat_d;
  logic                             resp_valid_q, resp_valid_d;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [ADDR_WIDTH-1:0]            mem_addr_q, mem_addr_d;
  logic                             mem_we_q, mem_we_d;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic [15:0]                      last_lat_q, last_lat_d;

  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    wb_addr_d    = wb_addr_q;
    seen_low_d   = seen_low_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_din_d    = mem_din_q;
    last_lat_d   = last_lat_q;
    if ((state_q != IDLE) && (lat_q != 16'hFFFF)) begin
      lat_d = lat_q + 16'd1;
    end else begin
      lat_d = lat_q;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_addr_d = block_base(req_addr);
          wb_addr_d = block_base(req_wb_addr);
          mem_din_d = req_wb_data;
          lat_d     = 16'd0;
          if (req_dirty) begin
            state_d    = WB_KICK;
            mem_addr_d = block_base(req_wb_addr) ^ KICK_BIT;
          end else begin
            state_d    = RD_KICK;
            mem_addr_d = block_base(req_addr) ^ KICK_BIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WB_KICK: begin
        seen_low_d = 1'b0;
        mem_addr_d = wb_addr_q;
        mem_we_d   = 1'b1;
        state_d    = WB_WAIT;
      end
      // A high mem_valid before it has been seen low belongs to the previous operation.
      WB_WAIT: begin
        if (!mem_valid) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          mem_addr_d = rd_addr_q ^ KICK_BIT;
          mem_we_d   = 1'b0;
          state_d    = RD_KICK;
        end else begin
          seen_low_d = seen_low_q;
        end
      end
      RD_KICK: begin
        seen_low_d = 1'b0;
        mem_addr_d = rd_addr_q;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (!mem_valid) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          resp_data_d  = mem_block_dout;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          seen_low_d = seen_low_q;
        end
      end
      RESP: begin
        last_lat_d = lat_d;
        state_d    = IDLE;
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      wb_addr_q    <= '0;
      seen_low_q   <= 1'b0;
      lat_q        <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_din_q    <= '0;
      last_lat_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      wb_addr_q    <= wb_addr_d;
      seen_low_q   <= seen_low_d;
      lat_q        <= lat_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_din_q    <= mem_din_d;
      last_lat_q   <= last_lat_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_block_din = mem_din_q;
  assign last_latency  = last_lat_q;

endmodule
